// File: rtl/pipelined_controller_if.sv
//-----------------------------------------------------------------------------
// pipelined_controller_if
//
// Bus between the RISC-V datapath and the pipelined control unit.
//   master : datapath side, drives the ID instruction fields and the EX branch
//            resolution, receives stall/flush, the stage controls, forwarding
//            selects and halted.
//   slave  : controller side (pipelined_controller).
//
// Signals:
//   id_opcode[4:0]      inst[6:2] of the instruction in ID
//   id_func3[2:0]       inst[14:12]
//   id_func7            inst[30]
//   id_rs1/id_rs2/id_rd ID register indices
//   ex_branch_taken     EX resolved a taken branch/JAL/JALR this cycle
//   stall, flush        PC/IF-ID hold, IF-ID + ID-EX squash
//   ex_*_sel            EX operand selects
//   mem_dm_w_en         store byte enables in MEM
//   wb_en, wb_sel, wb_rd  write-back controls
//   fwd_rs1/2_sel       EX operand source: 00 regfile, 01 MEM, 10 WB
//   halted              ECALL retired, core frozen
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

interface pipelined_controller_if #(
  parameter int REG_ADDR_W = 5,
  parameter int DM_MASK_W  = 4
);
  logic [4:0]            id_opcode;
  logic [2:0]            id_func3;
  logic                  id_func7;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  ex_branch_taken;

  logic                  stall;
  logic                  flush;
  logic                  ex_alu_src1_sel;
  logic                  ex_alu_src2_sel;
  logic                  ex_jb_src1_sel;
  logic [DM_MASK_W-1:0]  mem_dm_w_en;
  logic                  wb_en;
  logic                  wb_sel;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [1:0]            fwd_rs1_sel;
  logic [1:0]            fwd_rs2_sel;
  logic                  halted;

  modport master (
    output id_opcode, id_func3, id_func7, id_rs1, id_rs2, id_rd, ex_branch_taken,
    input  stall, flush, ex_alu_src1_sel, ex_alu_src2_sel, ex_jb_src1_sel,
           mem_dm_w_en, wb_en, wb_sel, wb_rd, fwd_rs1_sel, fwd_rs2_sel, halted
  );

  modport slave (
    input  id_opcode, id_func3, id_func7, id_rs1, id_rs2, id_rd, ex_branch_taken,
    output stall, flush, ex_alu_src1_sel, ex_alu_src2_sel, ex_jb_src1_sel,
           mem_dm_w_en, wb_en, wb_sel, wb_rd, fwd_rs1_sel, fwd_rs2_sel, halted
  );
endinterface

// File: rtl/pipelined_controller.sv
//-----------------------------------------------------------------------------
// pipelined_controller
//
// Control unit for the 5-stage RISC-V pipeline. Decodes the ID instruction,
// carries its controls through ID/EX, EX/MEM and MEM/WB, detects data hazards,
// produces branch/jump flush, operand-forwarding selects and runs the ECALL
// drain/halt state machine.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (pipeline -> bubbles, FSM -> RUN)
//   ctl    pipelined_controller_if.slave (ID fields and EX branch resolution
//          in; stall, flush, stage controls, forwarding selects, halted out)
//
// Parameters:
//   REG_ADDR_W    register-index width
//   DM_MASK_W     store byte-enable width (4 or 8)
//   DRAIN_CYCLES  cycles from ECALL leaving EX until halted asserts
//
// Build option:
//   CTRL_FORWARD_EN defined   : MEM/WB forwarding, stall only on load-use.
//   CTRL_FORWARD_EN undefined : no forwarding (selects tied to 00); stall on
//                               any RAW dependency against EX, MEM or WB until
//                               the producer has left WB.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module pipelined_controller #(
  parameter int REG_ADDR_W   = 5,
  parameter int DM_MASK_W    = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_controller_if.slave ctl
);

  localparam logic [4:0] OP_R_R    = 5'b01100;
  localparam logic [4:0] OP_R_I    = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_ECALL  = 5'b11100;

  localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef struct packed {
    logic                  wb_en;
    logic                  wb_sel;     // also marks a LOAD
    logic                  alu_src1;
    logic                  alu_src2;
    logic                  jb_src1;
    logic                  is_ecall;
    logic [DM_MASK_W-1:0]  dm_mask;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } ex_ctrl_t;

  typedef struct packed {
    logic                  wb_en;
    logic                  wb_sel;
    logic [DM_MASK_W-1:0]  dm_mask;
    logic [REG_ADDR_W-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic                  wb_en;
    logic                  wb_sel;
    logic [REG_ADDR_W-1:0] rd;
  } wb_ctrl_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Byte enables for SB/SH/SW; SD only exists on an 8-lane data memory.
  function automatic logic [DM_MASK_W-1:0] store_mask(input logic [2:0] f3);
    logic [DM_MASK_W-1:0] m;
    m = '0;
    case (f3)
      3'b000: m[0]   = 1'b1;
      3'b001: m[1:0] = 2'b11;
      3'b010: m[3:0] = 4'hF;
      3'b011: if (DM_MASK_W == 8) m = '1;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Unknown opcodes decode to an all-zero bubble.
  function automatic ex_ctrl_t decode(input logic [4:0]            op,
                                      input logic [2:0]            f3,
                                      input logic [REG_ADDR_W-1:0] rs1,
                                      input logic [REG_ADDR_W-1:0] rs2,
                                      input logic [REG_ADDR_W-1:0] rd);
    ex_ctrl_t c;
    logic     valid;
    c     = '0;
    valid = 1'b1;
    case (op)
      OP_R_R:    begin c.wb_en = 1'b1; c.alu_src2 = 1'b1; end
      OP_R_I:    c.wb_en = 1'b1;
      OP_LOAD:   begin c.wb_en = 1'b1; c.wb_sel = 1'b1; end
      OP_STORE:  c.dm_mask = store_mask(f3);
      OP_BRANCH: c.alu_src2 = 1'b1;
      OP_JAL:    begin c.wb_en = 1'b1; c.alu_src1 = 1'b1; end
      OP_JALR:   begin c.wb_en = 1'b1; c.alu_src1 = 1'b1; c.jb_src1 = 1'b1; end
      OP_LUI:    c.wb_en = 1'b1;
      OP_AUIPC:  begin c.wb_en = 1'b1; c.alu_src1 = 1'b1; end
      OP_ECALL:  c.is_ecall = 1'b1;
      default:   valid = 1'b0;
    endcase
    if (valid) begin
      c.rd  = rd;
      c.rs1 = rs1;
      c.rs2 = rs2;
    end
    return c;
  endfunction

  // {rs2_used, rs1_used} for the ID instruction.
  function automatic logic [1:0] rs_used(input logic [4:0] op);
    logic [1:0] u;
    u = 2'b00;
    case (op)
      OP_R_R, OP_STORE, OP_BRANCH: u = 2'b11;
      OP_R_I, OP_LOAD, OP_JALR, OP_ECALL: u = 2'b01;
      default: u = 2'b00;
    endcase
    return u;
  endfunction

  // A producer writing x0 never creates a dependency.
  function automatic logic raw_hit(input logic                  we,
                                   input logic [REG_ADDR_W-1:0] rd,
                                   input logic [1:0]            used,
                                   input logic [REG_ADDR_W-1:0] rs1,
                                   input logic [REG_ADDR_W-1:0] rs2);
    return we && (rd != '0) &&
           ((used[0] && (rd == rs1)) || (used[1] && (rd == rs2)));
  endfunction

  // MEM is the younger producer, so it wins over WB.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                         input mem_ctrl_t             m,
                                         input wb_ctrl_t              w);
    if (m.wb_en && (m.rd != '0) && (m.rd == rs)) return 2'b01;
    if (w.wb_en && (w.rd != '0) && (w.rd == rs)) return 2'b10;
    return 2'b00;
  endfunction

  ex_ctrl_t  id_dec;
  logic [1:0] id_used;
  ex_ctrl_t  ex_p0;
  mem_ctrl_t mem_p1;
  wb_ctrl_t  wb_p2;

  state_t            state;
  logic [CNT_W-1:0]  drain_cnt;
  logic              fsm_stall;
  logic              halted_q;

  logic       flush;
  logic       stall;
  logic       data_hazard;
  logic [1:0] fwd_rs1;
  logic [1:0] fwd_rs2;

  // func7 does not affect any control this unit produces.
  logic unused_func7;
  assign unused_func7 = ctl.id_func7;

  always_comb begin
    id_dec  = decode(ctl.id_opcode, ctl.id_func3, ctl.id_rs1, ctl.id_rs2, ctl.id_rd);
    id_used = rs_used(ctl.id_opcode);
  end

  assign flush = ctl.ex_branch_taken;

`ifdef CTRL_FORWARD_EN
  // Only a load in EX cannot be forwarded in time; one bubble resolves it.
  assign data_hazard = ex_p0.wb_sel &&
                       raw_hit(ex_p0.wb_en, ex_p0.rd, id_used, ctl.id_rs1, ctl.id_rs2);
  assign fwd_rs1 = fwd_sel(ex_p0.rs1, mem_p1, wb_p2);
  assign fwd_rs2 = fwd_sel(ex_p0.rs2, mem_p1, wb_p2);
`else
  // Without forwarding the consumer waits until the producer has left WB.
  assign data_hazard =
    raw_hit(ex_p0.wb_en,  ex_p0.rd,  id_used, ctl.id_rs1, ctl.id_rs2) ||
    raw_hit(mem_p1.wb_en, mem_p1.rd, id_used, ctl.id_rs1, ctl.id_rs2) ||
    raw_hit(wb_p2.wb_en,  wb_p2.rd,  id_used, ctl.id_rs1, ctl.id_rs2);
  assign fwd_rs1 = 2'b00;
  assign fwd_rs2 = 2'b00;
  logic unused_ex_rs;
  assign unused_ex_rs = ^{ex_p0.rs1, ex_p0.rs2};
`endif

  // Flush wins: a squashed instruction must not hold the front end.
  assign stall = !flush && (data_hazard || fsm_stall);

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_p0 <= '0;
    end else if (flush || stall) begin
      ex_p0 <= '0;
    end else begin
      ex_p0 <= id_dec;
    end
  end

  // ---- EX -> MEM boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_p1 <= '0;
    end else begin
      mem_p1.wb_en   <= ex_p0.wb_en;
      mem_p1.wb_sel  <= ex_p0.wb_sel;
      mem_p1.dm_mask <= ex_p0.dm_mask;
      mem_p1.rd      <= ex_p0.rd;
    end
  end

  // ---- MEM -> WB boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_p2 <= '0;
    end else begin
      wb_p2.wb_en  <= mem_p1.wb_en;
      wb_p2.wb_sel <= mem_p1.wb_sel;
      wb_p2.rd     <= mem_p1.rd;
    end
  end

  // ECALL drain/halt. The counter covers the instructions still ahead of the
  // ECALL in MEM and WB; once they retire the core freezes until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      fsm_stall <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (ex_p0.is_ecall && !flush) begin
            fsm_stall <= 1'b1;
            if (DRAIN_CYCLES == 0) begin
              state    <= ST_HALT;
              halted_q <= 1'b1;
            end else begin
              state     <= ST_DRAIN;
              drain_cnt <= CNT_W'(DRAIN_CYCLES);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt <= CNT_W'(1)) begin
            drain_cnt <= '0;
            state     <= ST_HALT;
            halted_q  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_HALT: begin
          fsm_stall <= 1'b1;
          halted_q  <= 1'b1;
        end
        default: begin
          state     <= ST_RUN;
          drain_cnt <= '0;
          fsm_stall <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ctl.stall           = stall;
  assign ctl.flush           = flush;
  assign ctl.ex_alu_src1_sel = ex_p0.alu_src1;
  assign ctl.ex_alu_src2_sel = ex_p0.alu_src2;
  assign ctl.ex_jb_src1_sel  = ex_p0.jb_src1;
  assign ctl.mem_dm_w_en     = mem_p1.dm_mask;
  assign ctl.wb_en           = wb_p2.wb_en;
  assign ctl.wb_sel          = wb_p2.wb_sel;
  assign ctl.wb_rd           = wb_p2.rd;
  assign ctl.fwd_rs1_sel     = fwd_rs1;
  assign ctl.fwd_rs2_sel     = fwd_rs2;
  assign ctl.halted          = halted_q;

endmodule

// File: tb/tb_pipelined_controller.sv
`timescale 1ns/1ps

module tb_pipelined_controller;

  localparam int RAW = 5;
  localparam int DMW = 4;

  localparam logic [4:0] OP_R_R    = 5'b01100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_ECALL  = 5'b11100;
  localparam logic [4:0] OP_NOP    = 5'b11111;

`ifdef CTRL_FORWARD_EN
  localparam int         LU_STALLS = 1;
  localparam logic [1:0] LU_FWD    = 2'b10;
  localparam logic       PR_STALL0 = 1'b0;
  localparam int         PR_STALLS = 0;
  localparam logic [1:0] PR_FWD    = 2'b01;
`else
  localparam int         LU_STALLS = 3;
  localparam logic [1:0] LU_FWD    = 2'b00;
  localparam logic       PR_STALL0 = 1'b1;
  localparam int         PR_STALLS = 3;
  localparam logic [1:0] PR_FWD    = 2'b00;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pipelined_controller_if #(.REG_ADDR_W(RAW), .DM_MASK_W(DMW)) bus ();

  pipelined_controller #(
    .REG_ADDR_W(RAW),
    .DM_MASK_W(DMW),
    .DRAIN_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctl  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [4:0] op, input logic [2:0] f3,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    bus.id_opcode = op;
    bus.id_func3  = f3;
    bus.id_func7  = 1'b0;
    bus.id_rs1    = r1;
    bus.id_rs2    = r2;
    bus.id_rd     = rd;
  endtask

  task automatic drain();
    put(OP_NOP, 3'b000, 5'd0, 5'd0, 5'd0);
    bus.ex_branch_taken = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ex_branch_taken = 1'b0;
    put(OP_NOP, 3'b000, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", bus.stall); end
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b want 0", bus.flush); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", bus.halted); end
    checks++; if ({bus.wb_en, bus.wb_sel, bus.mem_dm_w_en} !== 6'b0) begin errors++; $display("FAIL rst_wb_mem: got %b want 0", {bus.wb_en, bus.wb_sel, bus.mem_dm_w_en}); end
    checks++; if ({bus.ex_alu_src1_sel, bus.ex_alu_src2_sel, bus.ex_jb_src1_sel} !== 3'b000) begin errors++; $display("FAIL rst_ex_sels: got %b want 000", {bus.ex_alu_src1_sel, bus.ex_alu_src2_sel, bus.ex_jb_src1_sel}); end
    checks++; if ({bus.fwd_rs1_sel, bus.fwd_rs2_sel} !== 4'b0000) begin errors++; $display("FAIL rst_fwd: got %b want 0000", {bus.fwd_rs1_sel, bus.fwd_rs2_sel}); end
    // stream R_R x1 = x2 op x3 so the pipeline is full, then reset mid-stream
    @(posedge clk); #1;
    rst_n = 1'b1;
    put(OP_R_R, 3'b000, 5'd2, 5'd3, 5'd1);
    repeat (3) tick();
    @(negedge clk);
    checks++; if (bus.wb_en !== 1'b1) begin errors++; $display("FAIL pre_rst_wb_en: got %b want 1", bus.wb_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.wb_en !== 1'b0) begin errors++; $display("FAIL async_rst_wb_en: got %b want 0", bus.wb_en); end
    checks++; if (bus.ex_alu_src2_sel !== 1'b0) begin errors++; $display("FAIL async_rst_ex: got %b want 0", bus.ex_alu_src2_sel); end
    // release with R_R in ID: EX after 1 edge, WB after 3
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    checks++; if ({bus.ex_alu_src1_sel, bus.ex_alu_src2_sel} !== 2'b01) begin errors++; $display("FAIL rr_ex_sels: got %b want 01", {bus.ex_alu_src1_sel, bus.ex_alu_src2_sel}); end
    tick();
    @(negedge clk);
    checks++; if (bus.wb_en !== 1'b0) begin errors++; $display("FAIL rr_wb_early: got %b want 0", bus.wb_en); end
    tick();
    @(negedge clk);
    checks++; if ({bus.wb_en, bus.wb_sel, bus.wb_rd} !== {1'b1, 1'b0, 5'd1}) begin errors++; $display("FAIL rr_wb: got %b want 1_0_00001", {bus.wb_en, bus.wb_sel, bus.wb_rd}); end
    drain();
  endtask

  task automatic test_store_masks();
    put(OP_LOAD, 3'b010, 5'd1, 5'd0, 5'd7);
    tick();
    put(OP_STORE, 3'b000, 5'd2, 5'd3, 5'd0);
    tick();
    put(OP_STORE, 3'b001, 5'd2, 5'd3, 5'd0);
    @(negedge clk);
    checks++; if (bus.mem_dm_w_en !== 4'b0000) begin errors++; $display("FAIL mask_load: got %b want 0000", bus.mem_dm_w_en); end
    checks++; if (bus.ex_alu_src2_sel !== 1'b0) begin errors++; $display("FAIL store_src2: got %b want 0", bus.ex_alu_src2_sel); end
    tick();
    put(OP_STORE, 3'b010, 5'd2, 5'd3, 5'd0);
    @(negedge clk);
    checks++; if (bus.mem_dm_w_en !== 4'b0001) begin errors++; $display("FAIL mask_sb: got %b want 0001", bus.mem_dm_w_en); end
    checks++; if ({bus.wb_en, bus.wb_sel, bus.wb_rd} !== {1'b1, 1'b1, 5'd7}) begin errors++; $display("FAIL load_wb: got %b want 1_1_00111", {bus.wb_en, bus.wb_sel, bus.wb_rd}); end
    tick();
    put(OP_STORE, 3'b011, 5'd2, 5'd3, 5'd0);
    @(negedge clk);
    checks++; if (bus.mem_dm_w_en !== 4'b0011) begin errors++; $display("FAIL mask_sh: got %b want 0011", bus.mem_dm_w_en); end
    tick();
    put(OP_STORE, 3'b100, 5'd2, 5'd3, 5'd0);
    @(negedge clk);
    checks++; if (bus.mem_dm_w_en !== 4'b1111) begin errors++; $display("FAIL mask_sw: got %b want 1111", bus.mem_dm_w_en); end
    tick();
    put(OP_NOP, 3'b000, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checks++; if (bus.mem_dm_w_en !== 4'b0000) begin errors++; $display("FAIL mask_sd_on_4: got %b want 0000", bus.mem_dm_w_en); end
    tick();
    @(negedge clk);
    checks++; if (bus.mem_dm_w_en !== 4'b0000) begin errors++; $display("FAIL mask_f3_100: got %b want 0000", bus.mem_dm_w_en); end
    drain();
  endtask

  task automatic test_load_use();
    int n;
    put(OP_LOAD, 3'b010, 5'd1, 5'd0, 5'd5);
    tick();
    put(OP_R_R, 3'b000, 5'd5, 5'd1, 5'd6);
    @(negedge clk);
    checks++; if ({bus.stall, bus.flush} !== 2'b10) begin errors++; $display("FAIL lu_stall: got %b want 10", {bus.stall, bus.flush}); end
    tick();
    @(negedge clk);
    checks++; if ({bus.ex_alu_src1_sel, bus.ex_alu_src2_sel} !== 2'b00) begin errors++; $display("FAIL lu_bubble: got %b want 00", {bus.ex_alu_src1_sel, bus.ex_alu_src2_sel}); end
    n = 1;
    while (bus.stall && n < 10) begin
      n++;
      tick();
      @(negedge clk);
    end
    checks++; if (n != LU_STALLS) begin errors++; $display("FAIL lu_stall_cycles: got %0d want %0d", n, LU_STALLS); end
    tick();
    put(OP_NOP, 3'b000, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checks++; if (bus.fwd_rs1_sel !== LU_FWD) begin errors++; $display("FAIL lu_fwd_rs1: got %b want %b", bus.fwd_rs1_sel, LU_FWD); end
    checks++; if (bus.fwd_rs2_sel !== 2'b00) begin errors++; $display("FAIL lu_fwd_rs2: got %b want 00", bus.fwd_rs2_sel); end
    checks++; if (bus.ex_alu_src2_sel !== 1'b1) begin errors++; $display("FAIL lu_add_in_ex: got %b want 1", bus.ex_alu_src2_sel); end
    drain();
  endtask

  task automatic test_fwd_priority();
    int n;
    put(OP_R_R, 3'b000, 5'd1, 5'd2, 5'd3);
    tick();
    tick();
    put(OP_R_R, 3'b000, 5'd3, 5'd3, 5'd4);
    @(negedge clk);
    checks++; if (bus.stall !== PR_STALL0) begin errors++; $display("FAIL pr_stall: got %b want %b", bus.stall, PR_STALL0); end
    n = 0;
    while (bus.stall && n < 10) begin
      n++;
      tick();
      @(negedge clk);
    end
    checks++; if (n != PR_STALLS) begin errors++; $display("FAIL pr_stall_cycles: got %0d want %0d", n, PR_STALLS); end
    tick();
    put(OP_NOP, 3'b000, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checks++; if ({bus.fwd_rs1_sel, bus.fwd_rs2_sel} !== {PR_FWD, PR_FWD}) begin errors++; $display("FAIL pr_fwd: got %b want %b", {bus.fwd_rs1_sel, bus.fwd_rs2_sel}, {PR_FWD, PR_FWD}); end
    drain();
    // producer writing x0 never forwards or stalls, but still carries wb_en
    put(OP_R_R, 3'b000, 5'd1, 5'd2, 5'd0);
    tick();
    put(OP_R_R, 3'b000, 5'd0, 5'd0, 5'd4);
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", bus.stall); end
    tick();
    put(OP_NOP, 3'b000, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checks++; if ({bus.fwd_rs1_sel, bus.fwd_rs2_sel} !== 4'b0000) begin errors++; $display("FAIL x0_fwd: got %b want 0000", {bus.fwd_rs1_sel, bus.fwd_rs2_sel}); end
    tick();
    @(negedge clk);
    checks++; if ({bus.wb_en, bus.wb_rd} !== {1'b1, 5'd0}) begin errors++; $display("FAIL x0_wb: got %b want 1_00000", {bus.wb_en, bus.wb_rd}); end
    drain();
  endtask

  task automatic test_flush_vs_stall();
    put(OP_LOAD, 3'b010, 5'd1, 5'd0, 5'd5);
    tick();
    put(OP_R_R, 3'b000, 5'd5, 5'd1, 5'd6);
    bus.ex_branch_taken = 1'b1;
    @(negedge clk);
    checks++; if ({bus.flush, bus.stall} !== 2'b10) begin errors++; $display("FAIL fvs_flush_stall: got %b want 10", {bus.flush, bus.stall}); end
    tick();
    bus.ex_branch_taken = 1'b0;
    put(OP_NOP, 3'b000, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checks++; if ({bus.ex_alu_src2_sel, bus.flush, bus.stall} !== 3'b000) begin errors++; $display("FAIL fvs_bubble: got %b want 000", {bus.ex_alu_src2_sel, bus.flush, bus.stall}); end
    drain();
    // a plain flush squashes an independent R_R in ID
    put(OP_R_R, 3'b000, 5'd2, 5'd3, 5'd1);
    bus.ex_branch_taken = 1'b1;
    tick();
    bus.ex_branch_taken = 1'b0;
    put(OP_NOP, 3'b000, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checks++; if (bus.ex_alu_src2_sel !== 1'b0) begin errors++; $display("FAIL flush_squash: got %b want 0", bus.ex_alu_src2_sel); end
    drain();
  endtask

  task automatic test_jump_decode();
    put(OP_JALR, 3'b000, 5'd2, 5'd0, 5'd1);
    tick();
    put(OP_AUIPC, 3'b000, 5'd0, 5'd0, 5'd8);
    @(negedge clk);
    checks++; if ({bus.ex_alu_src1_sel, bus.ex_alu_src2_sel, bus.ex_jb_src1_sel} !== 3'b101) begin errors++; $display("FAIL jalr_sels: got %b want 101", {bus.ex_alu_src1_sel, bus.ex_alu_src2_sel, bus.ex_jb_src1_sel}); end
    tick();
    put(OP_LUI, 3'b000, 5'd0, 5'd0, 5'd9);
    @(negedge clk);
    checks++; if ({bus.ex_alu_src1_sel, bus.ex_alu_src2_sel, bus.ex_jb_src1_sel} !== 3'b100) begin errors++; $display("FAIL auipc_sels: got %b want 100", {bus.ex_alu_src1_sel, bus.ex_alu_src2_sel, bus.ex_jb_src1_sel}); end
    tick();
    put(OP_BRANCH, 3'b000, 5'd10, 5'd11, 5'd0);
    @(negedge clk);
    checks++; if ({bus.ex_alu_src1_sel, bus.ex_alu_src2_sel, bus.ex_jb_src1_sel} !== 3'b000) begin errors++; $display("FAIL lui_sels: got %b want 000", {bus.ex_alu_src1_sel, bus.ex_alu_src2_sel, bus.ex_jb_src1_sel}); end
    tick();
    put(OP_JAL, 3'b000, 5'd0, 5'd0, 5'd12);
    @(negedge clk);
    checks++; if ({bus.ex_alu_src1_sel, bus.ex_alu_src2_sel, bus.ex_jb_src1_sel} !== 3'b010) begin errors++; $display("FAIL branch_sels: got %b want 010", {bus.ex_alu_src1_sel, bus.ex_alu_src2_sel, bus.ex_jb_src1_sel}); end
    tick();
    put(OP_NOP, 3'b000, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checks++; if ({bus.ex_alu_src1_sel, bus.ex_alu_src2_sel, bus.ex_jb_src1_sel} !== 3'b100) begin errors++; $display("FAIL jal_sels: got %b want 100", {bus.ex_alu_src1_sel, bus.ex_alu_src2_sel, bus.ex_jb_src1_sel}); end
    drain();
  endtask

  task automatic test_ecall();
    // ECALL squashed by a coincident taken branch is ignored
    put(OP_ECALL, 3'b000, 5'd0, 5'd0, 5'd0);
    tick();
    put(OP_NOP, 3'b000, 5'd0, 5'd0, 5'd0);
    bus.ex_branch_taken = 1'b1;
    @(negedge clk);
    checks++; if ({bus.flush, bus.stall} !== 2'b10) begin errors++; $display("FAIL ecall_flushed: got %b want 10", {bus.flush, bus.stall}); end
    tick();
    bus.ex_branch_taken = 1'b0;
    tick();
    @(negedge clk);
    checks++; if ({bus.stall, bus.halted} !== 2'b00) begin errors++; $display("FAIL ecall_ignored: got %b want 00", {bus.stall, bus.halted}); end
    drain();
    // real ECALL: DRAIN for two cycles, then HALT
    put(OP_ECALL, 3'b000, 5'd0, 5'd0, 5'd0);
    tick();
    put(OP_NOP, 3'b000, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL ecall_ex_halted: got %b want 0", bus.halted); end
    tick();
    @(negedge clk);
    checks++; if ({bus.stall, bus.halted} !== 2'b10) begin errors++; $display("FAIL drain1: got %b want 10", {bus.stall, bus.halted}); end
    tick();
    @(negedge clk);
    checks++; if ({bus.stall, bus.halted} !== 2'b10) begin errors++; $display("FAIL drain2: got %b want 10", {bus.stall, bus.halted}); end
    tick();
    @(negedge clk);
    checks++; if ({bus.stall, bus.halted} !== 2'b11) begin errors++; $display("FAIL halt: got %b want 11", {bus.stall, bus.halted}); end
    put(OP_R_R, 3'b000, 5'd2, 5'd3, 5'd1);
    repeat (3) tick();
    @(negedge clk);
    checks++; if ({bus.stall, bus.halted, bus.wb_en} !== 3'b110) begin errors++; $display("FAIL halt_held: got %b want 110", {bus.stall, bus.halted, bus.wb_en}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.stall, bus.halted} !== 2'b00) begin errors++; $display("FAIL halt_async_rst: got %b want 00", {bus.stall, bus.halted}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if ({bus.stall, bus.halted, bus.wb_en} !== 3'b001) begin errors++; $display("FAIL run_after_rst: got %b want 001", {bus.stall, bus.halted, bus.wb_en}); end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_store_masks();
    test_load_use();
    test_fwd_priority();
    test_flush_vs_stall();
    test_jump_decode();
    test_ecall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_controller.md
Name: pipelined_controller

Overview:
- Parametrised successor to the combinational decode controller for the RISC-V pipeline CPU.
- Decodes the ID-stage opcode/func3/func7 and carries control through ID/EX, EX/MEM and MEM/WB registers.
- Adds load-use hazard stall, branch/jump flush, operand-forwarding selects and an ECALL drain/halt state machine.

Parameters:
- REG_ADDR_W, 5, register-index width.
- DM_MASK_W, 4, data-memory byte-enable width (4 or 8).
- DRAIN_CYCLES, 2, cycles from ECALL leaving EX until `halted` asserts (one per remaining stage).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_opcode  in  5  inst[6:2] of the ID instruction.
- id_func3  in  3  inst[14:12].
- id_func7  in  1  inst[30].
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W each  ID register indices.
- ex_branch_taken  in  1  EX resolved a taken branch, JAL or JALR this cycle.
- stall  out  1  hold PC and IF/ID.
- flush  out  1  squash IF/ID and ID/EX.
- ex_alu_src1_sel  out  1  1 = pc, 0 = rs1.
- ex_alu_src2_sel  out  1  1 = rs2, 0 = imm.
- ex_jb_src1_sel  out  1  1 = rs1 (JALR), 0 = pc.
- mem_dm_w_en  out  DM_MASK_W  store byte enables in MEM.
- wb_en  out  1  register write in WB.
- wb_sel  out  1  1 = load data, 0 = ALU.
- wb_rd  out  REG_ADDR_W  WB destination.
- fwd_rs1_sel, fwd_rs2_sel  out  2 each  EX operand source: 00 = regfile, 01 = MEM, 10 = WB.
- halted  out  1  ECALL retired, core frozen.

Behaviour:
- Opcodes: R_R 01100, R_I 00100, LOAD 00000, STORE 01000, BRANCH 11000, JAL 11011, JALR 11001, LUI 01101, AUIPC 00101, ECALL 11100. Anything else decodes as a bubble (all controls 0).
- Decode:
  - wb_en = 1 for R_R, R_I, LOAD, JALR, LUI, AUIPC, JAL.
  - alu_src1 = 1 for AUIPC, JAL, JALR.
  - alu_src2 = 1 for R_R, BRANCH.
  - jb_src1 = 1 for JALR.
  - wb_sel = 1 for LOAD.
  - Store masks: SB = low 1 bit set, SH = low 2, SW = low 4. SD (func3 011) sets all 8 only when DM_MASK_W == 8; otherwise 0. Other func3 give 0.
- rs1 is "used" by all except LUI, AUIPC, JAL. rs2 is "used" by R_R, STORE, BRANCH.
- Any write with rd == 0 is treated as no write for hazard and forwarding purposes, but wb_en still propagates.
- ID/EX register, each edge:
  - flush or stall: load a bubble.
  - otherwise: load the decoded ID controls.
- EX/MEM and MEM/WB shift every cycle unconditionally.
- Latency: ID→EX outputs 1 cycle, MEM outputs 2 cycles, WB outputs 3 cycles.
- flush = ex_branch_taken (combinational). Flush has priority over stall; stall is masked while flush = 1.
- stall = load-use OR fsm_stall.
  - load-use: EX holds a LOAD with rd ≠ 0, rd equals a used ID rs1/rs2, and flush = 0.
  - A load-use stall lasts exactly 1 cycle; the bubble resolves it.
- Forwarding, per EX operand:
  - MEM match (wb_en, rd ≠ 0, rd == rs) → 01.
  - else WB match → 10.
  - else 00.
  - MEM wins when both match.
- FSM states:
  - RUN: fsm_stall = 0. A non-flushed ECALL in EX → DRAIN, counter = DRAIN_CYCLES.
  - DRAIN: fsm_stall = 1, decrement counter each cycle; counter reaching 0 → HALT.
  - HALT: fsm_stall = 1, halted = 1. Only rst_n exits.
  - ECALL flushed by a simultaneous ex_branch_taken is ignored.
- Reset (async, rst_n = 0):
  - All pipeline registers become bubbles, FSM = RUN, counter = 0.
  - stall, flush, halted, wb_en, mem_dm_w_en, all selects = 0.
  - Reset mid-DRAIN or in HALT returns to RUN immediately.

Optional Feature:
- Macro: CTRL_FORWARD_EN.
- Defined: forwarding as above; stalls only on load-use.
- Undefined: fwd_* tied to 00. stall asserts whenever a used ID rs matches a writing rd ≠ 0 in EX, MEM or WB, and holds until the producer has passed WB (up to 3 cycles).

Test Plan:
- Reset: rst_n = 0 mid-stream → all outputs 0 asynchronously; after release, R_R in ID → wb_en = 1 three edges later.
- Store masks: SB/SH/SW in ID → mem_dm_w_en 0001/0011/1111 two cycles later. With DM_MASK_W = 8, SD → 8'hFF.
- Load-use: LOAD x5, then ADD x6, x5, x1 → stall = 1 for one cycle, bubble in EX, then fwd_rs1_sel = 10 when ADD reaches EX.
- Forward priority: ADD x3, then ADD x3, then ADD x4, x3, x3 → fwd_rs1_sel = fwd_rs2_sel = 01. rd = x0 producer → 00.
- Flush vs stall: load-use condition coincident with ex_branch_taken = 1 → flush = 1, stall = 0, ID/EX bubble.
- ECALL: ECALL in EX → stall = 1 immediately, halted = 1 after 2 cycles and held; rst_n pulse → halted = 0, state RUN.
